// File: rtl/pdm_sched.sv
// Sample scheduler and soft-mute controller for the 1st-order PDM output stage.
// Streams samples through a small FIFO, strobes the PDM stage and ramps gain at every start/stop.
module pdm_sched #(
   parameter int DIV_W   = 8,
   parameter int OSR_W   = 6,
   parameter int FIFO_AW = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [DIV_W-1:0]   cfg_div,
   input  logic [OSR_W-1:0]   cfg_osr,
   input  logic               run,
   input  logic               mute,
   input  logic               s_valid,
   input  logic [15:0]        s_data,
   output logic               s_ready,
   output logic               pdm_ena,
   output logic [15:0]        pdm_in,
   output logic [FIFO_AW:0]   fill,
   output logic               underflow,
   input  logic               clr_flags,
   output logic [2:0]         state
);

   localparam int DEPTH = 2 ** FIFO_AW;

   // s_valid/s_ready: a sample transfers on every clock edge where both are high;
   // s_ready depends only on registered FIFO occupancy, never on s_valid.

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RAMP_UP = 3'd1,
      S_RUN     = 3'd2,
      S_RAMP_DN = 3'd3,
      S_MUTED   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DIV_W-1:0]    r_div_cnt;
   logic [DIV_W-1:0]    w_div_load;
   logic                r_ena;
   logic [OSR_W-1:0]    r_hold;
   logic [8:0]          r_gain;
   logic [8:0]          w_gain_nxt;
   logic signed [15:0]  r_sample;
   logic signed [15:0]  w_sample_nxt;
   logic [15:0]         r_pdm_in;
   logic signed [25:0]  w_samp_ext;
   logic signed [25:0]  w_gain_ext;
   logic signed [25:0]  w_prod;
   logic [15:0]         w_pdm_nxt;

   logic [15:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wr_ptr;
   logic [FIFO_AW-1:0]  r_rd_ptr;
   logic [FIFO_AW:0]    r_fill;
   logic                r_uf;

   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_live;
   logic                w_fetch;
   logic                w_uf_evt;
   logic                w_stop;

   // Occupancy never exceeds DEPTH, so its top bit alone means full.
   assign w_full     = r_fill[FIFO_AW];
   assign w_empty    = (r_fill == '0);
   assign w_push     = s_valid & ~w_full;
   assign w_live     = (r_state == S_RAMP_UP) || (r_state == S_RUN);
   assign w_fetch    = r_ena && (r_state != S_IDLE) && (r_hold == '0);
   assign w_uf_evt   = w_fetch && w_empty && w_live;
   assign w_stop     = !run || mute || w_uf_evt;
   assign w_div_load = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (run && !mute && !w_empty) w_state_nxt = S_RAMP_UP;
         end
         S_RAMP_UP: begin
            if (r_ena) begin
               if (w_stop)                  w_state_nxt = (r_gain <= 9'd1) ? S_MUTED : S_RAMP_DN;
               else if (r_gain == 9'd255)   w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_ena && w_stop) w_state_nxt = S_RAMP_DN;
         end
         S_RAMP_DN: begin
            if (r_ena && (r_gain <= 9'd1)) w_state_nxt = S_MUTED;
         end
         S_MUTED: begin
            if (r_ena) begin
               if (!run)                      w_state_nxt = S_IDLE;
               else if (!mute && !w_empty)    w_state_nxt = S_RAMP_UP;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_gain_nxt = r_gain;
      if (r_ena) begin
         case (r_state)
            S_RAMP_UP: w_gain_nxt = w_stop ? ((r_gain == '0) ? '0 : r_gain - 9'd1) : r_gain + 9'd1;
            S_RUN:     w_gain_nxt = w_stop ? 9'd255 : 9'd256;
            S_RAMP_DN: w_gain_nxt = (r_gain == '0) ? '0 : r_gain - 9'd1;
            default:   w_gain_nxt = '0;
         endcase
      end
      w_pop        = w_fetch && !w_empty && (w_live || (r_state == S_RAMP_DN));
      w_sample_nxt = w_pop ? r_mem[r_rd_ptr] : r_sample;
   end

   // Gain is zero-extended so 256 stays positive; 256 is exact unity after the shift.
   assign w_samp_ext = {{10{w_sample_nxt[15]}}, w_sample_nxt};
   assign w_gain_ext = {17'd0, w_gain_nxt};
   assign w_prod     = w_samp_ext * w_gain_ext;
   assign w_pdm_nxt  = 16'(w_prod >>> 8);

   always_ff @(posedge clk) begin
      if (!reset_n || (r_state == S_IDLE)) begin
         r_div_cnt <= '0;
         r_ena     <= 1'b0;
      end else begin
         r_ena <= (r_div_cnt == '0);
         if (r_div_cnt == '0) r_div_cnt <= w_div_load;
         else                 r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n || (r_state == S_IDLE)) begin
         r_hold <= '0;
      end else if (r_ena) begin
         if (r_hold == '0) r_hold <= cfg_osr;
         else              r_hold <= r_hold - OSR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_gain   <= '0;
         r_sample <= '0;
         r_pdm_in <= '0;
      end else if (r_ena) begin
         r_gain   <= w_gain_nxt;
         r_sample <= w_sample_nxt;
         r_pdm_in <= w_pdm_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + (FIFO_AW+1)'(1);
            2'b01:   r_fill <= r_fill - (FIFO_AW+1)'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_data;
   end

   // A new underflow event beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!reset_n)       r_uf <= 1'b0;
      else if (w_uf_evt)  r_uf <= 1'b1;
      else if (clr_flags) r_uf <= 1'b0;
   end

   assign s_ready   = ~w_full;
   assign pdm_ena   = r_ena;
   assign pdm_in    = r_pdm_in;
   assign fill      = r_fill;
   assign underflow = r_uf;
   assign state     = r_state;

endmodule
